// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and constants for the pipelined adder/subtractor.
//   calc_stages  - number of CHUNK-bit slices in a WIDTH-bit datapath
//   addsub_flags_t - status flags delivered alongside each result
//   sat_max/sat_min - signed saturation limits, returned in a MaxWidth-bit word
//                     (callers keep the low WIDTH bits)
package addsub_pkg;

  localparam int unsigned MaxWidth  = 1024;
  localparam int unsigned MaxStages = 16;

  function automatic int unsigned calc_stages(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  typedef struct packed {
    logic c_out;
    logic ovf;
    logic zero;
    logic neg;
  } addsub_flags_t;

  // 0111..1 in the low `width` bits
  function automatic logic [MaxWidth-1:0] sat_max(input int unsigned width);
    logic [MaxWidth-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return (one << (width - 1)) - one;
  endfunction

  // 1000..0 in the low `width` bits
  function automatic logic [MaxWidth-1:0] sat_min(input int unsigned width);
    logic [MaxWidth-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return one << (width - 1);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: one Chunk-bit registered adder slice.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   en_i          - advance enable (low while the pipeline is stalled)
//   a_i, b_i, c_i - operand chunk (b already conditioned for subtract) and carry-in
//   sum_o, c_o    - registered chunk sum and carry-out
//   ovf_o         - registered signed overflow, meaningful only for the MSB slice
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int unsigned Chunk = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Chunk-1:0] a_i,
  input  logic [Chunk-1:0] b_i,
  input  logic             c_i,
  output logic [Chunk-1:0] sum_o,
  output logic             c_o,
  output logic             ovf_o
);

  logic [Chunk:0]   total;
  logic             c_msb;
  logic [Chunk-1:0] sum_q;
  logic             c_q;
  logic             ovf_q;

  always_comb begin
    total = {1'b0, a_i} + {1'b0, b_i} + {{Chunk{1'b0}}, c_i};
    // Carry into the top bit recovered from that bit's sum and operands.
    c_msb = total[Chunk-1] ^ a_i[Chunk-1] ^ b_i[Chunk-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      sum_q <= total[Chunk-1:0];
      c_q   <= total[Chunk];
      ovf_q <= total[Chunk] ^ c_msb;
    end
  end

  assign sum_o = sum_q;
  assign c_o   = c_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtractor, one CHUNK-bit slice per stage.
//   clk, rst_n             - clock, asynchronous active-low reset
//   in_valid/in_ready      - operand handshake (in_ready = not stalled)
//   a_in, b_in, c_in, sub  - operands, carry/borrow-in, 1 = subtract
//   out_valid/out_ready    - result handshake
//   sum_out, c_out, ovf, zero, neg - result and flags, STAGES cycles after acceptance
// Build option: define ADDSUB_SAT_EN to clamp overflowing results to signed max/min.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned Stages = calc_stages(WIDTH, CHUNK);
  localparam int unsigned Last   = Stages - 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("addsub_pipe: WIDTH must be a multiple of CHUNK");
  end
  if (Stages == 0 || Stages > MaxStages) begin : g_bad_stages
    $error("addsub_pipe: WIDTH/CHUNK must be between 1 and 16");
  end
  if (WIDTH > MaxWidth) begin : g_bad_width
    $error("addsub_pipe: WIDTH too large");
  end

  // Handshake: a single global stall freezes every register in the pipe.
  logic              stall;
  logic              adv;
  logic [Stages-1:0] valid_q;
  logic [Stages-1:0] valid_d;

  assign stall    = valid_q[Last] & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  always_comb begin
    valid_d = (valid_q << 1) | Stages'(in_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q <= valid_d;
    end
  end

  // Datapath
  logic [WIDTH-1:0]  b_eff;
  logic [CHUNK-1:0]  a_op  [Stages];
  logic [CHUNK-1:0]  b_op  [Stages];
  logic [CHUNK-1:0]  sum_s [Stages];
  logic [Stages-1:0] ci_s;
  logic [Stages-1:0] co_s;
  logic [Stages-1:0] ovf_s;
  logic [WIDTH-1:0]  sum_raw;

  assign b_eff = b_in ^ {WIDTH{sub}};

  for (genvar k = 0; k < Stages; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_op[k] = a_in[CHUNK-1:0];
      assign b_op[k] = b_eff[CHUNK-1:0];
      assign ci_s[k] = c_in ^ sub;
    end else begin : g_skew
      // Chunk k waits k cycles so it meets the carry coming up from slice k-1.
      logic [CHUNK-1:0] a_skew_q [k];
      logic [CHUNK-1:0] b_skew_q [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < k; i++) begin
            a_skew_q[i] <= '0;
            b_skew_q[i] <= '0;
          end
        end else if (adv) begin
          a_skew_q[0] <= a_in[k*CHUNK +: CHUNK];
          b_skew_q[0] <= b_eff[k*CHUNK +: CHUNK];
          for (int i = 1; i < k; i++) begin
            a_skew_q[i] <= a_skew_q[i-1];
            b_skew_q[i] <= b_skew_q[i-1];
          end
        end
      end

      assign a_op[k] = a_skew_q[k-1];
      assign b_op[k] = b_skew_q[k-1];
      assign ci_s[k] = co_s[k-1];
    end

    addsub_slice #(
      .Chunk (CHUNK)
    ) u_slice (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .en_i   (adv),
      .a_i    (a_op[k]),
      .b_i    (b_op[k]),
      .c_i    (ci_s[k]),
      .sum_o  (sum_s[k]),
      .c_o    (co_s[k]),
      .ovf_o  (ovf_s[k])
    );

    if (k == Last) begin : g_tail
      assign sum_raw[k*CHUNK +: CHUNK] = sum_s[k];
    end else begin : g_deskew
      // Hold early chunks until the MSB slice finishes the same beat.
      localparam int unsigned Depth = Stages - 1 - k;
      logic [CHUNK-1:0] dly_q [Depth];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < Depth; i++) begin
            dly_q[i] <= '0;
          end
        end else if (adv) begin
          dly_q[0] <= sum_s[k];
          for (int i = 1; i < Depth; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end

      assign sum_raw[k*CHUNK +: CHUNK] = dly_q[Depth-1];
    end
  end

  // Only the MSB slice's overflow is architecturally meaningful.
  if (Stages > 1) begin : g_unused_ovf
    logic unused_ovf;
    assign unused_ovf = ^ovf_s[Stages-2:0];
  end

  logic [WIDTH-1:0] sum_fin;

`ifdef ADDSUB_SAT_EN
  localparam logic [MaxWidth-1:0] SatMaxW = sat_max(WIDTH);
  localparam logic [MaxWidth-1:0] SatMinW = sat_min(WIDTH);

  // Sign of operand A travels with the MSB slice; on overflow it gives the true result sign.
  logic sat_neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_neg_q <= 1'b0;
    end else if (adv) begin
      sat_neg_q <= a_op[Last][CHUNK-1];
    end
  end

  always_comb begin
    sum_fin = sum_raw;
    if (ovf_s[Last]) begin
      sum_fin = sat_neg_q ? SatMinW[WIDTH-1:0] : SatMaxW[WIDTH-1:0];
    end
  end
`else
  assign sum_fin = sum_raw;
`endif

  addsub_flags_t flags;

  always_comb begin
    flags.c_out = co_s[Last];
    flags.ovf   = ovf_s[Last];
    flags.neg   = sum_fin[WIDTH-1];
    // Qualified by valid so an idle or freshly reset pipe does not report zero.
    flags.zero  = valid_q[Last] & (sum_fin == '0);
  end

  assign out_valid = valid_q[Last];
  assign sum_out   = sum_fin;
  assign c_out     = flags.c_out;
  assign ovf       = flags.ovf;
  assign zero      = flags.zero;
  assign neg       = flags.neg;

endmodule
